// File: rtl/vga_palette_if.sv
// Bus bundle between the pixel generator / host and the colour lookup table.
//
// Handshake: the pixel stream is valid-only. The palette never stalls, so
// there is no ready; a pixel is accepted on every rising clk edge where
// pix_valid is high, and rgb/rgb_valid present it exactly two edges later.
// The host port has no handshake either: wr_en and pal_restore act on the
// edge where they are sampled high, and rd_data follows rd_idx one edge later.
interface vga_palette_if #(
  parameter int IDX_W = 4
);
  // pixel stream in
  logic             pix_valid;
  logic [IDX_W-1:0] pix_idx;
  logic             pix_blink;
  logic             pix_blank;
  logic             frame_tick;
  // colour stream out
  logic             rgb_valid;
  logic [7:0]       rgb;
  logic             blink_phase;
  // host write / readback / restore
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_data;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_data;
  logic             pal_restore;

  // generator + host side
  modport master (
    output pix_valid, pix_idx, pix_blink, pix_blank, frame_tick,
    output wr_en, wr_idx, wr_data, rd_idx, pal_restore,
    input  rgb_valid, rgb, blink_phase, rd_data
  );

  // palette side
  modport slave (
    input  pix_valid, pix_idx, pix_blink, pix_blank, frame_tick,
    input  wr_en, wr_idx, wr_data, rd_idx, pal_restore,
    output rgb_valid, rgb, blink_phase, rd_data
  );
endinterface

// File: rtl/vga_palette.sv
// Programmable RGB332 colour lookup table with a 2-stage pixel pipeline,
// host write/readback port, restore-to-defaults and a frame-counted blink.
// Palette storage is a flop array so the 16-colour defaults exist straight
// out of reset without any initialisation sequence.
module vga_palette #(
  parameter int IDX_W        = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_palette_if.slave  bus
);

  localparam int         ENTRIES    = 2 ** IDX_W;
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  // Classic 16-colour decode; anything above 15 boots as black.
  function automatic logic [7:0] default_entry(input int idx);
    logic [7:0] val;
    case (idx)
      0:       val = 8'h00; // black
      1:       val = 8'hA0; // red
      2:       val = 8'h14; // green
      3:       val = 8'hFC; // yellow
      4:       val = 8'h03; // blue
      5:       val = 8'hA2; // magenta
      6:       val = 8'h16; // cyan
      7:       val = 8'hFF; // white
      8:       val = 8'h49; // gray
      9:       val = 8'hE0; // bright red
      10:      val = 8'h1C; // bright green
      11:      val = 8'hFD; // bright yellow
      12:      val = 8'h6F; // bright blue
      13:      val = 8'hE3; // bright magenta
      14:      val = 8'h5F; // bright cyan
      15:      val = 8'hFF; // white
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  // ---------------------------------------------------------------------
  // Palette storage: one register per entry, each with its own default.
  // Lookups read pal[] before the edge, so a same-edge write or restore is
  // only seen by lookups from the following edge onwards.
  // ---------------------------------------------------------------------
  logic [7:0] pal [ENTRIES];

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    localparam logic [7:0] DEF = default_entry(g);
    logic [7:0] entry_q;

    // restore beats write; write only lands on the addressed entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_q <= DEF;
      end else if (bus.pal_restore) begin
        entry_q <= DEF;
      end else if (bus.wr_en && (bus.wr_idx == IDX_W'(g))) begin
        entry_q <= bus.wr_data;
      end
    end

    assign pal[g] = entry_q;
  end

  // ---------------------------------------------------------------------
  // Blink timing
  // ---------------------------------------------------------------------
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_phase_q, blink_phase_d;

  // count frame ticks; wrap and flip the phase after BLINK_FRAMES of them
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (bus.frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = 8'h00;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'h01;
      end
    end
  end

  // blink counter and phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= 8'h00;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline stage 1: capture the incoming pixel attributes
  // ---------------------------------------------------------------------
  logic             s1_valid_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic             s1_blink_q;
  logic             s1_blank_q;

  // register the pixel as presented; no stall, one pixel per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_blink_q <= 1'b0;
      s1_blank_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.pix_valid;
      s1_idx_q   <= bus.pix_idx;
      s1_blink_q <= bus.pix_blink;
      s1_blank_q <= bus.pix_blank;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline stage 2: colour lookup
  // ---------------------------------------------------------------------
  logic [7:0] rgb_q, rgb_d;
  logic       rgb_valid_q, rgb_valid_d;

  // blank forces black, blink-on shows the background entry, else lookup;
  // idle slots always drive black
  always_comb begin
    rgb_d       = 8'h00;
    rgb_valid_d = s1_valid_q;
    if (s1_valid_q && !s1_blank_q) begin
      if (s1_blink_q && blink_phase_q) begin
        rgb_d = pal[0];
      end else begin
        rgb_d = pal[s1_idx_q];
      end
    end
  end

  // stage-2 output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q       <= 8'h00;
      rgb_valid_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  // ---------------------------------------------------------------------
  // Host readback
  // ---------------------------------------------------------------------
  logic [7:0] rd_data_q;

  // sample the addressed entry every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= pal[bus.rd_idx];
    end
  end

  assign bus.rgb         = rgb_q;
  assign bus.rgb_valid   = rgb_valid_q;
  assign bus.blink_phase = blink_phase_q;
  assign bus.rd_data     = rd_data_q;

endmodule
